// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int unsigned API_ADDR_WIDTH = 32;
    localparam int unsigned API_DATA_WIDTH = 32;
    localparam int unsigned ROM_BYTES      = 8192;

    localparam logic [API_ADDR_WIDTH-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [API_DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [API_ADDR_WIDTH-1:0] pc;
        logic [API_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [API_ADDR_WIDTH-1:0] align_word(input logic [API_ADDR_WIDTH-1:0] a);
        return {a[API_ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries between the ROM response and decode.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    localparam int unsigned CW = $clog2(QDEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    fetch_entry_t  mem_q [QDEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CW'(QDEPTH)) || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues ROM reads, queues responses for decode, handles redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = fetch_unit_pkg::RESET_PC,
    parameter int unsigned QDEPTH    = 2,
    parameter int unsigned ROM_BYTES = fetch_unit_pkg::ROM_BYTES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic                      rom_en_o,
    output logic [API_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [API_DATA_WIDTH-1:0] rom_data_i,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [API_DATA_WIDTH-1:0] instr_o,
    output logic [API_ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                      redirect_i,
    input  logic [API_ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                      fault_o
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [API_ADDR_WIDTH-1:0] pc_q;
    logic [API_ADDR_WIDTH-1:0] inflight_pc_q;
    logic                      inflight_q;
    logic                      fault_q;

    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    fetch_entry_t  head;
    fetch_entry_t  resp;
    logic          pop;
    logic          in_bound;
    logic          issue;

    assign pop       = instr_valid_o & instr_ready_i;
    assign in_bound  = pc_q < API_ADDR_WIDTH'(ROM_BYTES);
    // Slots committed once this cycle settles: queued + in flight - leaving now.
    assign occupancy = {1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    // Gating with reset_n keeps the ROM idle while reset is held.
    assign issue     = reset_n && !redirect_i && !fault_q && in_bound &&
                       (occupancy < (CW + 1)'(QDEPTH));

    assign rom_en_o   = issue;
    assign rom_addr_o = issue ? pc_q : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= align_word(RESET_PC);
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            fault_q       <= 1'b0;
        end else if (redirect_i) begin
            pc_q       <= align_word(redirect_pc_i);
            inflight_q <= 1'b0;
            fault_q    <= (redirect_pc_i[1:0] != 2'b00);
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 32'd4;
            end
            if (!in_bound) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign resp = '{pc: inflight_pc_q, instr: rom_data_i};

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (redirect_i),
        .push_i  (inflight_q & ~redirect_i),
        .entry_i (resp),
        .pop_i   (pop),
        .head_o  (head),
        .valid_o (instr_valid_o),
        .count_o (count)
    );

    assign instr_o    = head.instr;
    assign instr_pc_o = head.pc;
    assign fault_o    = fault_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM enable and byte address.
- Absorbs the ROM's 1-cycle read latency in a small PC/instruction queue and presents instructions to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap) from execute by flushing and restarting at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, queue entries; must be >= 2 for 1 instr/cycle throughput.
- ROM_BYTES, 8192, ROM size; addresses >= ROM_BYTES are out of bound.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rom_en_o  out  1  ROM read enable; ROM returns data the following cycle.
- rom_addr_o  out  32  byte address of the fetch; always word aligned.
- rom_data_i  in  32  ROM read data, valid the cycle after rom_en_o was high.
- instr_valid_o  out  1  queue head valid.
- instr_ready_i  in  1  decode accepts the head this cycle.
- instr_o  out  32  instruction at queue head.
- instr_pc_o  out  32  PC of instr_o.
- redirect_i  in  1  one-cycle redirect request.
- redirect_pc_i  in  32  redirect target.
- fault_o  out  1  sticky fetch fault: misaligned redirect or out-of-bound PC.

Behaviour:
- Reset (async assert): pc=RESET_PC, queue empty, inflight=0, fault_o=0, rom_en_o=0, rom_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- Reset deasserted mid-operation discards everything; fetch restarts at RESET_PC.
- Outputs: rom_en_o and rom_addr_o are combinational from pc and state; instr_* come from the registered queue head.
- Issue condition (rom_en_o=1, rom_addr_o=pc), all of these must hold:
  - !redirect_i and !fault_o;
  - pc < ROM_BYTES;
  - count + inflight - (instr_valid_o & instr_ready_i) < QDEPTH.
- On issue: pc <= pc+4, with 32-bit wrap; inflight <= 1 next cycle; the issued pc is captured for the response.
- Response: when inflight=1, {captured pc, rom_data_i} is written to the queue tail that cycle.
- Latency: issue in cycle N -> data enqueued at end of N+1 -> instr_valid_o=1 in N+2.
- Steady state with ready held high: one instruction per cycle.
- Dequeue: when instr_valid_o & instr_ready_i, the head pops. Simultaneous enqueue and dequeue keeps count unchanged.
- Queue is never overrun, guaranteed by the issue rule. Asserting instr_ready_i while empty has no effect.
- Redirect (redirect_i=1 in cycle R):
  - queue flushed, any response arriving in R dropped, no issue in R;
  - pc <= {redirect_pc_i[31:2],2'b00}; fault_o cleared;
  - first fetch of the new PC in R+1, instr_valid_o in R+3.
  - Redirect has priority over enqueue, dequeue and issue in the same cycle.
- Misaligned redirect (redirect_pc_i[1:0]!=0): pc is aligned as above and fault_o=1 from R+1, so fetch halts until the next redirect.
- Out-of-bound PC: if pc >= ROM_BYTES with no redirect, fault_o <= 1 and no issue. Queued instructions still drain. fault_o clears only on redirect or reset.
- Widths: pc, rom_addr_o and instr_pc_o are 32 bits; count is clog2(QDEPTH+1) bits.

Decomposition:
- Shared package/header holds API_ADDR_WIDTH (32), API_DATA_WIDTH (32), ROM_BYTES (8192), RESET_PC, and the NOP encoding 32'h0000_0013.
- One sub-module: fetch_queue.
  - Synchronous FIFO of {pc, instr} entries, parameter QDEPTH.
  - Flush input, count output, async active-low reset.
- fetch_unit holds the pc, inflight and fault logic, plus the issue rule.

Test Plan:
- Release reset, ready=1, ROM word0=32'h00000013, word1=32'h00100093 -> rom_addr_o 0,4,8 on consecutive cycles; instr_valid_o first high 2 cycles after first issue with instr_o=32'h00000013, instr_pc_o=0, then 32'h00100093, pc=4.
- ready=0 for 10 cycles after reset -> exactly 2 issues (addr 0,4), then rom_en_o=0; raising ready drains pc 0,4 in order, then fetch resumes at 8 with no gap in steady state.
- Redirect to 32'h0000_0100 while queue full and a response is in flight -> queue empty the next cycle, no stale instruction delivered, next instr_pc_o=32'h100, valid 3 cycles after redirect.
- Redirect to 32'h0000_0102 -> fault_o=1 next cycle, rom_en_o stays 0; a later redirect to 32'h0000_0200 clears fault_o and fetches at 32'h200.
- Redirect to 32'h0000_1FFC with ready=1 -> one fetch at 1FFC, then fault_o=1 and no access at 32'h2000; instruction at 1FFC is still delivered.
- Assert reset_n low mid-stream with queue occupied -> all outputs 0 immediately; after release the first rom_addr_o=RESET_PC.
